// File: rtl/n64_joybus_pkg.sv
// Shared Joybus definitions: command codes, response lengths and the
// sequencer's phase/state encodings, used by the scheduler, PHY and fake pad.
package n64_joybus_pkg;

    localparam logic [7:0] CMD_STATUS = 8'h00;
    localparam logic [7:0] CMD_POLL   = 8'h01;
    localparam logic [7:0] CMD_RESET  = 8'hFF;

    localparam logic [2:0] LEN_RESET  = 3'd3;
    localparam logic [2:0] LEN_STATUS = 3'd3;
    localparam logic [2:0] LEN_POLL   = 3'd4;

    typedef enum logic [1:0] {
        PHASE_RESET,
        PHASE_INFO,
        PHASE_POLL
    } phase_e;

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_SEND,
        ST_RECV
    } state_e;

    function automatic logic [7:0] phaseCmd(input phase_e phase);
        case (phase)
            PHASE_INFO: return CMD_STATUS;
            PHASE_POLL: return CMD_POLL;
            default:    return CMD_RESET;
        endcase
    endfunction

    function automatic logic [2:0] phaseLen(input phase_e phase);
        case (phase)
            PHASE_INFO: return LEN_STATUS;
            PHASE_POLL: return LEN_POLL;
            default:    return LEN_RESET;
        endcase
    endfunction

endpackage

// File: rtl/n64_resp_collector.sv
// Gathers one Joybus response: counts bytes, shifts the first four into a
// 32-bit word, and flags the end of the frame (stop bit or timeout).
module n64_resp_collector #(
    parameter int RESP_TIMEOUT = 400
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        en_i,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_byte_i,
    input  logic        rx_stop_i,
    input  logic [2:0]  exp_len_i,
    output logic        done_o,
    output logic        ok_o,
    output logic [31:0] data_o
);

    localparam int TW = $clog2(RESP_TIMEOUT + 1);

    logic [2:0]    count_q, count_d;
    logic [31:0]   shift_q, shift_d;
    logic [TW-1:0] tmo_q, tmo_d;

    // A byte arriving with the stop bit is counted before the length check,
    // and a stop seen on the expiry edge takes priority over the timeout.
    always_comb begin
        count_d = count_q;
        shift_d = shift_q;
        tmo_d   = tmo_q;
        done_o  = 1'b0;
        ok_o    = 1'b0;
        if (start_i) begin
            count_d = 3'd0;
            shift_d = 32'd0;
            tmo_d   = TW'(RESP_TIMEOUT - 1);
        end else if (en_i) begin
            if (rx_valid_i) begin
                if (count_q < 3'd4) begin
                    shift_d = {shift_q[23:0], rx_byte_i};
                end
                if (count_q != 3'd7) begin
                    count_d = count_q + 3'd1;
                end
            end
            if (rx_stop_i) begin
                done_o = 1'b1;
                ok_o   = (count_d == exp_len_i);
            end else if (tmo_q == '0) begin
                done_o = 1'b1;
            end else begin
                tmo_d = tmo_q - TW'(1);
            end
        end
    end

    assign data_o = shift_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= 3'd0;
            shift_q <= 32'd0;
            tmo_q   <= '0;
        end else begin
            count_q <= count_d;
            shift_q <= shift_d;
            tmo_q   <= tmo_d;
        end
    end

endmodule

// File: rtl/n64_poll_scheduler.sv
// Joybus host sequencer: brings the pad up with reset/info commands, then
// polls buttons at a fixed period, tracking errors, retries and presence.
module n64_poll_scheduler
    import n64_joybus_pkg::*;
#(
    parameter int POLL_PERIOD  = 16000,
    parameter int RESP_TIMEOUT = 400,
    parameter int MAX_RETRY    = 3
) (
    input  logic        sample_clk,
    input  logic        reset,
    output logic        cmd_valid,
    output logic [7:0]  cmd_byte,
    input  logic        cmd_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    input  logic        rx_stop,
    output logic [31:0] buttons,
    output logic        buttons_valid,
    output logic        present,
    output logic [15:0] dev_type,
    output logic [7:0]  err_count
);

    localparam int CW = $clog2(POLL_PERIOD + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam logic [CW-1:0] WAIT_LOAD = CW'(POLL_PERIOD - 1);

    state_e        state_q, state_d;
    phase_e        phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [31:0]   buttons_q, buttons_d;
    logic          buttonsValid_q, buttonsValid_d;
    logic          present_q, present_d;
    logic [15:0]   devType_q, devType_d;
    logic [7:0]    errCount_q, errCount_d;

    logic          handshake;
    logic          collDone;
    logic          collOk;
    logic [31:0]   collData;

    assign handshake = (state_q == ST_SEND) && cmd_ready;

    n64_resp_collector #(
        .RESP_TIMEOUT(RESP_TIMEOUT)
    ) u_collector (
        .clk_i      (sample_clk),
        .rst_i      (reset),
        .start_i    (handshake),
        .en_i       (state_q == ST_RECV),
        .rx_valid_i (rx_valid),
        .rx_byte_i  (rx_byte),
        .rx_stop_i  (rx_stop),
        .exp_len_i  (phaseLen(phase_q)),
        .done_o     (collDone),
        .ok_o       (collOk),
        .data_o     (collData)
    );

    always_comb begin
        state_d        = state_q;
        phase_d        = phase_q;
        cnt_d          = cnt_q;
        retry_d        = retry_q;
        buttons_d      = buttons_q;
        buttonsValid_d = 1'b0;
        present_d      = present_q;
        devType_d      = devType_q;
        errCount_d     = errCount_q;
        case (state_q)
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_SEND;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_SEND: begin
                if (cmd_ready) begin
                    state_d = ST_RECV;
                end
            end
            ST_RECV: begin
                if (collDone) begin
                    state_d = ST_WAIT;
                    cnt_d   = WAIT_LOAD;
                    if (collOk) begin
                        retry_d = '0;
                        case (phase_q)
                            PHASE_RESET: begin
                                devType_d = collData[23:8];
                                present_d = 1'b1;
                                phase_d   = PHASE_INFO;
                            end
                            PHASE_INFO: begin
                                devType_d = collData[23:8];
                                present_d = 1'b1;
                                phase_d   = PHASE_POLL;
                            end
                            default: begin
                                buttons_d      = collData;
                                buttonsValid_d = 1'b1;
                            end
                        endcase
                    end else begin
                        if (errCount_q != 8'hFF) begin
                            errCount_d = errCount_q + 8'd1;
                        end
                        // The retry counter never exceeds MAX_RETRY-1, so this
                        // failure is the one that declares the pad absent.
                        if (retry_q == RW'(MAX_RETRY - 1)) begin
                            present_d = 1'b0;
                            phase_d   = PHASE_RESET;
                            retry_d   = '0;
                        end else begin
                            retry_d = retry_q + RW'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = ST_WAIT;
                cnt_d   = WAIT_LOAD;
            end
        endcase
    end

    always_ff @(posedge sample_clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_WAIT;
            phase_q        <= PHASE_RESET;
            cnt_q          <= WAIT_LOAD;
            retry_q        <= '0;
            buttons_q      <= 32'd0;
            buttonsValid_q <= 1'b0;
            present_q      <= 1'b0;
            devType_q      <= 16'd0;
            errCount_q     <= 8'd0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            cnt_q          <= cnt_d;
            retry_q        <= retry_d;
            buttons_q      <= buttons_d;
            buttonsValid_q <= buttonsValid_d;
            present_q      <= present_d;
            devType_q      <= devType_d;
            errCount_q     <= errCount_d;
        end
    end

    assign cmd_valid     = (state_q == ST_SEND);
    assign cmd_byte      = phaseCmd(phase_q);
    assign buttons       = buttons_q;
    assign buttons_valid = buttonsValid_q;
    assign present       = present_q;
    assign dev_type      = devType_q;
    assign err_count     = errCount_q;

endmodule

// File: tb/tb_n64_poll_scheduler.sv
// Randomized self-checking bench for n64_poll_scheduler, acting as the PHY and
// comparing every transaction against a transaction-level model of the pad link.
module tb_n64_poll_scheduler;

    localparam int POLL_PERIOD  = 8;
    localparam int RESP_TIMEOUT = 20;
    localparam int MAX_RETRY    = 2;

    logic        sample_clk = 1'b0;
    logic        reset      = 1'b1;
    logic        cmd_ready  = 1'b1;
    logic        rx_valid   = 1'b0;
    logic [7:0]  rx_byte    = 8'd0;
    logic        rx_stop    = 1'b0;
    logic        cmd_valid;
    logic [7:0]  cmd_byte;
    logic [31:0] buttons;
    logic        buttons_valid;
    logic        present;
    logic [15:0] dev_type;
    logic [7:0]  err_count;

    int vectorCount = 0;
    int missCount   = 0;

    int          mPhase;
    int          mErr;
    int          mRetry;
    bit          mPresent;
    logic [15:0] mDev;
    logic [31:0] mButtons;

    n64_poll_scheduler #(
        .POLL_PERIOD  (POLL_PERIOD),
        .RESP_TIMEOUT (RESP_TIMEOUT),
        .MAX_RETRY    (MAX_RETRY)
    ) dut (
        .sample_clk    (sample_clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_byte      (cmd_byte),
        .cmd_ready     (cmd_ready),
        .rx_valid      (rx_valid),
        .rx_byte       (rx_byte),
        .rx_stop       (rx_stop),
        .buttons       (buttons),
        .buttons_valid (buttons_valid),
        .present       (present),
        .dev_type      (dev_type),
        .err_count     (err_count)
    );

    always #5 sample_clk = ~sample_clk;

    // Model phases: 0 = reset command, 1 = info command, 2 = button poll.
    function automatic logic [7:0] expCode(input int phase);
        if (phase == 0) return 8'hFF;
        if (phase == 1) return 8'h00;
        return 8'h01;
    endfunction

    function automatic int expLen(input int phase);
        return (phase == 2) ? 4 : 3;
    endfunction

    function automatic logic [7:0] payByte(input logic [63:0] pay, input int i);
        return pay[63 - 8*i -: 8];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic tick;
        @(posedge sample_clk);
        #1;
    endtask

    task automatic modelReset;
        mPhase   = 0;
        mErr     = 0;
        mRetry   = 0;
        mPresent = 1'b0;
        mDev     = 16'd0;
        mButtons = 32'd0;
    endtask

    task automatic modelUpdate(input bit success, input logic [63:0] pay, output bit expBv);
        expBv = 1'b0;
        if (success) begin
            mRetry = 0;
            if (mPhase == 2) begin
                mButtons = {payByte(pay, 0), payByte(pay, 1), payByte(pay, 2), payByte(pay, 3)};
                expBv    = 1'b1;
            end else begin
                mDev     = {payByte(pay, 0), payByte(pay, 1)};
                mPresent = 1'b1;
                mPhase   = mPhase + 1;
            end
        end else begin
            if (mErr < 255) mErr = mErr + 1;
            mRetry = mRetry + 1;
            if (mRetry >= MAX_RETRY) begin
                mPresent = 1'b0;
                mPhase   = 0;
                mRetry   = 0;
            end
        end
    endtask

    task automatic checkResetState;
        checkOutput("rstCmdValid", cmd_valid, 0);
        checkOutput("rstCmdByte", cmd_byte, 8'hFF);
        checkOutput("rstButtons", buttons, 0);
        checkOutput("rstBv", buttons_valid, 0);
        checkOutput("rstPresent", present, 0);
        checkOutput("rstDevType", dev_type, 0);
        checkOutput("rstErr", err_count, 0);
    endtask

    // Line noise outside a response must be ignored while waiting.
    task automatic waitCommand(input int startN);
        int n;
        n = startN;
        while (!cmd_valid && n < 100) begin
            rx_valid = 1'($urandom_range(0, 1));
            rx_stop  = 1'($urandom_range(0, 1));
            rx_byte  = 8'($urandom);
            tick;
            n++;
        end
        rx_valid = 1'b0;
        rx_stop  = 1'b0;
        checkOutput("cmdGap", n, POLL_PERIOD);
        checkOutput("cmdByte", cmd_byte, expCode(mPhase));
    endtask

    // mode 0: stop after the bytes, mode 1: no stop (timeout),
    // mode 2: stop arrives on the timeout edge itself.
    task automatic applyStimulus(input int nBytes, input int mode, input logic [63:0] pay);
        int  k;
        int  errBefore;
        bit  stopped;
        bit  success;
        bit  expBv;
        tick;
        checkOutput("cmdDrop", cmd_valid, 0);
        k = 0;
        stopped = 1'b0;
        for (int i = 0; i < nBytes; i++) begin
            if (mode == 0) begin
                repeat ($urandom_range(0, 1)) begin
                    tick;
                    k++;
                end
            end
            rx_valid = 1'b1;
            rx_byte  = payByte(pay, i);
            if (mode == 0 && i == nBytes - 1 && $urandom_range(0, 1) == 1) begin
                rx_stop = 1'b1;
                stopped = 1'b1;
            end
            tick;
            k++;
            rx_valid = 1'b0;
            rx_stop  = 1'b0;
        end
        if (mode == 0 && !stopped) begin
            repeat ($urandom_range(0, 1)) begin
                tick;
                k++;
            end
            rx_stop = 1'b1;
            tick;
            k++;
            rx_stop = 1'b0;
        end else if (mode == 1) begin
            errBefore = int'(err_count);
            while (int'(err_count) == errBefore && k < 40) begin
                tick;
                k++;
            end
            checkOutput("timeoutEdge", k, RESP_TIMEOUT);
        end else if (mode == 2) begin
            while (k < RESP_TIMEOUT - 1) begin
                tick;
                k++;
            end
            rx_stop = 1'b1;
            tick;
            k++;
            rx_stop = 1'b0;
        end
        success = (mode != 1) && (nBytes == expLen(mPhase));
        modelUpdate(success, pay, expBv);
        checkOutput("bvPulse", buttons_valid, expBv);
        checkOutput("buttons", buttons, mButtons);
        checkOutput("present", present, mPresent);
        checkOutput("devType", dev_type, mDev);
        checkOutput("errCount", err_count, mErr);
        tick;
        checkOutput("bvLow", buttons_valid, 0);
        waitCommand(1);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL globalTimeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        logic [63:0] pay;
        int          nBytes;
        int          mode;
        int          r;

        modelReset;
        reset = 1'b1;
        repeat (3) tick;
        checkResetState;
        reset = 1'b0;
        waitCommand(0);

        applyStimulus(3, 0, 64'h050002AA_00000000);
        applyStimulus(3, 0, 64'h050002BB_00000000);
        checkOutput("bringDev", dev_type, 16'h0500);
        checkOutput("bringPresent", present, 1);
        checkOutput("bringCmd", cmd_byte, 8'h01);

        applyStimulus(4, 0, 64'h800012F4_00000000);
        checkOutput("pollButtons", buttons, 32'h800012F4);

        applyStimulus(3, 0, 64'h11223344_55667788);
        checkOutput("shortErr", err_count, 1);
        checkOutput("shortCmd", cmd_byte, 8'h01);
        applyStimulus(3, 0, 64'h99AABBCC_DDEEFF00);
        checkOutput("absentPresent", present, 0);
        checkOutput("absentCmd", cmd_byte, 8'hFF);

        applyStimulus(3, 0, 64'h050002CC_00000000);
        applyStimulus(3, 0, 64'h050002DD_00000000);
        applyStimulus(0, 1, 64'd0);
        applyStimulus(4, 2, 64'h12345678_00000000);
        checkOutput("stopWins", buttons, 32'h12345678);

        tick;
        rx_valid = 1'b1;
        rx_byte  = 8'hA5;
        tick;
        rx_byte  = 8'h5A;
        tick;
        rx_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        modelReset;
        checkResetState;
        tick;
        tick;
        reset = 1'b0;
        waitCommand(0);

        for (int t = 0; t < 150; t++) begin
            pay = {32'($urandom), 32'($urandom)};
            nBytes = ($urandom_range(0, 1) == 1) ? expLen(mPhase) : $urandom_range(0, 7);
            r = $urandom_range(0, 9);
            mode = (r < 8) ? 0 : (r == 8) ? 1 : 2;
            applyStimulus(nBytes, mode, pay);
        end

        repeat (300) applyStimulus(0, 0, 64'd0);
        checkOutput("errSat", err_count, 8'd255);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
